// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared mspu core types and constants (sequencer, decoder, ALU).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [1:0]  WB_ALU   = 2'd0;
  localparam logic [1:0]  WB_MEM   = 2'd1;
  localparam logic [1:0]  WB_LINK  = 2'd2;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/core_sequencer_pc_next.sv
// ============================================================================
// Module      : pc_next
// Description : Combinational next-PC selector for the mspu sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next
  import core_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic            i_branch_en,
  input  logic            i_jal_en,
  input  logic            i_jalr_en,
  output logic [XLEN-1:0] o_next_pc
);

  logic w_take_rel;

  // Branch condition arrives on the ALU compare bit.
  assign w_take_rel = i_jal_en | (i_branch_en & i_alu_result[0]);

  always_comb begin
    o_next_pc = i_pc + 32'd4;
    if (i_jalr_en) begin
      o_next_pc = i_alu_result & ~32'h1;
    end else if (w_take_rel) begin
      o_next_pc = i_pc + i_imm;
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_sequencer.sv
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle fetch/decode/exec/mem/wb control FSM for the mspu
//               core; owns PC, IR, the shared bus handshake and instret.
//               Optional: MSPU_ILLEGAL_TRAP_EN halts on an illegal instruction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             bus_req,
  output logic             bus_we,
  output logic             bus_fetch,
  output logic [31:0]      bus_addr,
  input  logic             bus_ack,
  input  logic [31:0]      bus_rdata,
  output logic [31:0]      ir,
  output logic [31:0]      pc,
  input  logic             branch_en,
  input  logic             jal_en,
  input  logic             jalr_en,
  input  logic             mem_re,
  input  logic             mem_we,
  input  logic             reg_we,
  input  logic             insn_legal,
  input  logic [31:0]      imm,
  input  logic [31:0]      alu_result,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [31:0]      mem_rdata,
  output logic             retired,
  output logic [CNT_W-1:0] instret,
  output logic             halted
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_ir;
  logic [31:0]      r_mem_rdata;
  logic [CNT_W-1:0] r_instret;

  logic             w_ok;
  logic             w_branch;
  logic             w_jal;
  logic             w_jalr;
  logic             w_mem_op;
  logic [31:0]      w_next_pc;
  logic             w_in_fetch;
  logic             w_in_mem;

`ifdef MSPU_ILLEGAL_TRAP_EN
  // Illegal instructions never reach WB in trap mode.
  assign w_ok = 1'b1;
`else
  // Illegal instructions retire as a no-op: all side-effect flags masked.
  assign w_ok = insn_legal;
`endif

  assign w_branch = branch_en & w_ok;
  assign w_jal    = jal_en & w_ok;
  assign w_jalr   = jalr_en & w_ok;
  assign w_mem_op = (mem_re | mem_we) & w_ok;

  pc_next u_pc_next (
    .i_pc         (r_pc),
    .i_imm        (imm),
    .i_alu_result (alu_result),
    .i_branch_en  (w_branch),
    .i_jal_en     (w_jal),
    .i_jalr_en    (w_jalr),
    .o_next_pc    (w_next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= NOP_INSN;
      r_mem_rdata <= 32'h0;
      r_instret   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == FETCH && bus_ack) begin
        r_ir <= bus_rdata;
      end
      if (r_state == MEM && bus_ack) begin
        r_mem_rdata <= bus_rdata;
      end
      if (r_state == WB) begin
        r_pc      <= w_next_pc;
        r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH:  if (bus_ack) w_next_state = DECODE;
      DECODE: w_next_state = EXEC;
      EXEC: begin
        w_next_state = w_mem_op ? MEM : WB;
`ifdef MSPU_ILLEGAL_TRAP_EN
        if (!insn_legal) w_next_state = HALT;
`endif
      end
      MEM:    if (bus_ack) w_next_state = WB;
      WB:     w_next_state = FETCH;
      HALT:   w_next_state = HALT;
      default: w_next_state = FETCH;
    endcase
  end

  // Gating with reset drops the request the instant reset asserts.
  assign w_in_fetch = (r_state == FETCH) & ~reset;
  assign w_in_mem   = (r_state == MEM) & ~reset;

  always_comb begin
    bus_req   = w_in_fetch | w_in_mem;
    bus_fetch = w_in_fetch;
    bus_we    = w_in_mem & mem_we;
    bus_addr  = w_in_mem ? alu_result : r_pc;
    rf_we     = 1'b0;
    retired   = 1'b0;
    wb_sel    = WB_ALU;
    if (r_state == WB) begin
      rf_we   = reg_we & w_ok;
      retired = 1'b1;
      if (w_jal | w_jalr) begin
        wb_sel = WB_LINK;
      end else if (mem_re & w_ok) begin
        wb_sel = WB_MEM;
      end
    end
  end

`ifdef MSPU_ILLEGAL_TRAP_EN
  assign halted = (r_state == HALT);
`else
  assign halted = 1'b0;
`endif

  assign pc        = r_pc;
  assign ir        = r_ir;
  assign mem_rdata = r_mem_rdata;
  assign instret   = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// ============================================================================
// Module      : tb_core_sequencer
// Description : Scoreboard bench for core_sequencer (bus and retire monitors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_core_sequencer;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_req, bus_we, bus_fetch, bus_ack;
  logic [31:0] bus_addr, bus_rdata, ir, pc, imm, alu_result, mem_rdata, instret;
  logic        branch_en, jal_en, jalr_en, mem_re, mem_we, reg_we, insn_legal;
  logic        rf_we, retired, halted;
  logic [1:0]  wb_sel;

  always #5 clk = ~clk;

  core_sequencer #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .bus_req(bus_req), .bus_we(bus_we), .bus_fetch(bus_fetch), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .ir(ir), .pc(pc),
    .branch_en(branch_en), .jal_en(jal_en), .jalr_en(jalr_en), .mem_re(mem_re),
    .mem_we(mem_we), .reg_we(reg_we), .insn_legal(insn_legal), .imm(imm),
    .alu_result(alu_result), .rf_we(rf_we), .wb_sel(wb_sel), .mem_rdata(mem_rdata),
    .retired(retired), .instret(instret), .halted(halted)
  );

  typedef struct {
    logic        fetch;
    logic        we;
    logic [31:0] addr;
  } bus_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        rf_we;
    logic [1:0]  sel;
    logic [31:0] cnt;
    logic [31:0] next_pc;
    logic        chk_mem;
    logic [31:0] mem;
  } ret_exp_t;

  bus_exp_t    q_bus[$];
  ret_exp_t    q_ret[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'h0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus monitor: a handshake completes on the edge following req&ack.
  always @(negedge clk) begin
    bus_exp_t b;
    #1;
    if (!reset && bus_req && bus_ack) begin
      if (q_bus.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected: got addr %h expected no transaction", bus_addr);
      end else begin
        b = q_bus.pop_front();
        check32("bus_fetch", {31'h0, bus_fetch}, {31'h0, b.fetch});
        check32("bus_we", {31'h0, bus_we}, {31'h0, b.we});
        check32("bus_addr", bus_addr, b.addr);
      end
    end
  end

  // Retire monitor: WB-cycle outputs, then PC/instret one cycle later.
  logic     ret_pend = 1'b0;
  ret_exp_t r_cur;
  always @(negedge clk) begin
    #1;
    if (ret_pend) begin
      check32("next_pc", pc, r_cur.next_pc);
      check32("instret_inc", instret, r_cur.cnt + 32'd1);
      ret_pend = 1'b0;
    end
    if (rf_we && !retired) begin
      checks++; errors++;
      $display("FAIL rf_we_outside_wb: got 1 expected 0");
    end
    if (retired) begin
      if (q_ret.size() == 0) begin
        checks++; errors++;
        $display("FAIL retire_unexpected: got pc %h expected no retire", pc);
      end else begin
        r_cur = q_ret.pop_front();
        check32("ret_pc", pc, r_cur.pc);
        check32("ret_ir", ir, r_cur.ir);
        check32("rf_we", {31'h0, rf_we}, {31'h0, r_cur.rf_we});
        check32("wb_sel", {30'h0, wb_sel}, {30'h0, r_cur.sel});
        check32("instret", instret, r_cur.cnt);
        if (r_cur.chk_mem) check32("mem_rdata", mem_rdata, r_cur.mem);
        ret_pend = 1'b1;
      end
    end
  end

  task automatic serve(input int dly, input logic [31:0] data);
    int n = 0;
    while (!bus_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus_req) begin
      checks++; errors++;
      $display("FAIL bus_timeout: got no bus_req expected request");
      return;
    end
    repeat (dly) @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = data;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
  endtask

  task automatic issue(input logic [31:0] addr, input int fdly,
                       input logic br, input logic jal, input logic jalr,
                       input logic mre, input logic mwe, input logic rwe, input logic legal,
                       input logic [31:0] imm_v, input logic [31:0] alu_v,
                       input int mdly, input logic [31:0] ld,
                       input logic [31:0] nxt, input logic [1:0] sel, input logic exp_rfwe);
    bus_exp_t    b;
    ret_exp_t    r;
    logic        halts;
    logic [31:0] word;
    int          n;
    halts = 1'b0;
`ifdef MSPU_ILLEGAL_TRAP_EN
    halts = !legal;
`endif
    word = addr ^ 32'hA5A5_0013;
    branch_en = br; jal_en = jal; jalr_en = jalr; mem_re = mre; mem_we = mwe;
    reg_we = rwe; insn_legal = legal; imm = imm_v; alu_result = alu_v;
    b.fetch = 1'b1; b.we = 1'b0; b.addr = addr;
    q_bus.push_back(b);
    if (mre | mwe) begin
      b.fetch = 1'b0; b.we = mwe; b.addr = alu_v;
      q_bus.push_back(b);
    end
    if (!halts) begin
      r.pc = addr; r.ir = word; r.rf_we = exp_rfwe; r.sel = sel; r.cnt = exp_cnt;
      r.next_pc = nxt; r.chk_mem = mre; r.mem = ld;
      q_ret.push_back(r);
      exp_cnt = exp_cnt + 32'd1;
    end
    serve(fdly, word);
    if (mre | mwe) serve(mdly, ld);
    if (halts) begin
      repeat (8) @(negedge clk);
      #1;
      check32("halted", {31'h0, halted}, 32'h1);
      check32("halt_pc", pc, addr);
      check32("halt_req", {31'h0, bus_req}, 32'h0);
      check32("halt_instret", instret, exp_cnt);
    end else begin
      n = 0;
      while (!retired && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!retired) begin
        checks++; errors++;
        $display("FAIL retire_timeout: got no retire expected pc %h", addr);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
    branch_en = 0; jal_en = 0; jalr_en = 0; mem_re = 0; mem_we = 0; reg_we = 0;
    insn_legal = 1'b1; imm = 32'h0; alu_result = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check32("rst_pc", pc, 32'h0);
    check32("rst_ir", ir, 32'h0000_0013);
    check32("rst_req", {31'h0, bus_req}, 32'h0);
    check32("rst_rf_we", {31'h0, rf_we}, 32'h0);
    check32("rst_retired", {31'h0, retired}, 32'h0);
    check32("rst_instret", instret, 32'h0);
    check32("rst_mem_rdata", mem_rdata, 32'h0);
    check32("rst_halted", {31'h0, halted}, 32'h0);
    check32("rst_wb_sel", {30'h0, wb_sel}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    //     addr          fd br jal jalr mre mwe rwe lg imm           alu           md ld             next          sel rf
    issue(32'h0000_0000, 0, 0, 0,  0,   0,  0,  1,  1, 32'h0000_0005, 32'h0000_0005, 0, 32'h0,         32'h0000_0004, 2'd0, 1);
    issue(32'h0000_0004, 2, 0, 0,  0,   0,  0,  1,  1, 32'h0000_0040, 32'h0000_0007, 0, 32'h0,         32'h0000_0008, 2'd0, 1);
    issue(32'h0000_0008, 1, 0, 0,  0,   1,  0,  1,  1, 32'h0000_0100, 32'h0000_0100, 3, 32'hDEAD_BEEF, 32'h0000_000C, 2'd1, 1);
    issue(32'h0000_000C, 0, 0, 0,  0,   0,  1,  0,  1, 32'h0000_0004, 32'h0000_0104, 1, 32'h0,         32'h0000_0010, 2'd0, 0);
    issue(32'h0000_0010, 0, 0, 1,  0,   0,  0,  1,  1, 32'h0000_0010, 32'h0000_0033, 0, 32'h0,         32'h0000_0020, 2'd2, 1);
    issue(32'h0000_0020, 0, 1, 0,  0,   0,  0,  0,  1, 32'hFFFF_FFF8, 32'h0000_0001, 0, 32'h0,         32'h0000_0018, 2'd0, 0);
    issue(32'h0000_0018, 0, 0, 1,  0,   0,  0,  1,  1, 32'h0000_0008, 32'h0000_0000, 0, 32'h0,         32'h0000_0020, 2'd2, 1);
    issue(32'h0000_0020, 0, 1, 0,  0,   0,  0,  0,  1, 32'hFFFF_FFF8, 32'h0000_0002, 0, 32'h0,         32'h0000_0024, 2'd0, 0);
    issue(32'h0000_0024, 0, 0, 1,  0,   0,  0,  1,  1, 32'h0000_001C, 32'h0000_0000, 0, 32'h0,         32'h0000_0040, 2'd2, 1);
    issue(32'h0000_0040, 0, 0, 1,  0,   0,  0,  1,  1, 32'h0000_0010, 32'h0000_0000, 0, 32'h0,         32'h0000_0050, 2'd2, 1);
    issue(32'h0000_0050, 0, 0, 0,  1,   0,  0,  1,  1, 32'h0000_0010, 32'h0000_0203, 0, 32'h0,         32'h0000_0202, 2'd2, 1);
    issue(32'h0000_0202, 0, 0, 0,  1,   0,  0,  1,  1, 32'h0000_0010, 32'hFFFF_FFFD, 0, 32'h0,         32'hFFFF_FFFC, 2'd2, 1);
    issue(32'hFFFF_FFFC, 0, 0, 0,  0,   0,  0,  1,  1, 32'h0000_0100, 32'h0000_0009, 0, 32'h0,         32'h0000_0000, 2'd0, 1);
    issue(32'h0000_0000, 0, 0, 0,  0,   0,  0,  1,  0, 32'h0000_0100, 32'h0000_0009, 0, 32'h0,         32'h0000_0004, 2'd0, 0);

    // Reset while a load waits in MEM; the stranded ack must be ignored.
    branch_en = 0; jal_en = 0; jalr_en = 0; mem_re = 1; mem_we = 0; reg_we = 1;
    insn_legal = 1'b1; alu_result = 32'h0000_0300;
    n = 0;
    while (!bus_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus_req) begin
      q_bus.push_back('{fetch: 1'b1, we: 1'b0, addr: pc});
      serve(0, 32'h1234_5678);
      n = 0;
      while (!bus_req && n < 20) begin
        @(negedge clk);
        n++;
      end
      repeat (2) @(negedge clk);
      check32("mem_wait_req", {31'h0, bus_req}, 32'h1);
      reset = 1'b1;
      #1;
      check32("rst_mid_req", {31'h0, bus_req}, 32'h0);
      check32("rst_mid_pc", pc, 32'h0);
      check32("rst_mid_instret", instret, 32'h0);
      bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = 32'h0;
      reset = 1'b0;
      #1;
      check32("post_rst_fetch", {31'h0, bus_fetch}, 32'h1);
      check32("post_rst_addr", bus_addr, 32'h0);
      check32("post_rst_mem_rdata", mem_rdata, 32'h0);
      check32("post_rst_ir", ir, 32'h0000_0013);
      @(negedge clk);
    end else begin
      checks++; errors++;
      $display("FAIL pre_reset_req: got 0 expected 1");
    end

    exp_cnt = 32'h0;
    issue(32'h0000_0000, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0005, 32'h0000_0005, 0, 32'h0, 32'h0000_0004, 2'd0, 1);
    repeat (3) @(negedge clk);
    check32("bus_queue_empty", q_bus.size(), 32'h0);
    check32("ret_queue_empty", q_ret.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
